mux3_rr_arbiter: RTL and testbench
==================================

Name: mux3_rr_arbiter

Overview:
- Round-robin arbiter that shares one 3-input select mux between three requesters (a, b, c).
- Registers a one-hot grant and drives the mux's 2-bit select.
- Inserts a one-cycle turnaround between owners. Optionally limits how long one owner holds the mux.
- Sits directly in front of the 3:1 select mux. Its sel output drives the mux select pins.

Parameters:
- MAX_HOLD, 8: maximum consecutive granted cycles before forced release when another requester is waiting. Used only with HOLD_LIMIT_EN. Legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the hold counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  3  request: req[0]=a, req[1]=b, req[2]=c. Level, held for the whole transaction.
- grant  output  3  registered one-hot grant, same bit order as req. 000 = no owner.
- sel  output  2  mux select: a -> 11, b -> 10, c -> 01, none -> 00
- busy  output  1  high while any grant is asserted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: grant=000, sel=00, busy=0, state=IDLE, rr pointer=2 (so a has first priority), hold counter=0.
- Reset mid-operation: ownership is dropped on the next edge. No turnaround cycle.
- sel and busy are decoded combinationally from the grant register only. Never from req.
- FSM states:
  - IDLE: grant=000. If any req bit is set, pick a winner, load grant, go to OWN.
  - OWN: grant held constant. Hold counter increments each cycle, saturating at 2^CNT_W-1. Leave OWN when the owner's req drops, or on forced release. Either case clears grant and goes to TURN.
  - TURN: grant=000 for exactly one cycle. Counter cleared. Always returns to IDLE.
- Latency: req rising in IDLE at edge t gives grant at edge t+1. Owner req dropping at edge t gives grant=000 at t+1.
- Earliest next grant, to any requester: t+3 after the owner's req drops (OWN -> TURN -> IDLE -> OWN).
- Winner selection: search starts at pointer+1 mod 3, in ascending index with wrap 2->0. First set req bit wins. The pointer loads the winner's index when grant is loaded.
- Simultaneous requests in IDLE: only one winner, chosen by the rr order. The others wait with req held. No request is lost.
- Requests from non-owners during OWN or TURN are ignored until IDLE.
- The owner re-requesting after release competes normally. After a, the search starts at b.
- Reqs that are not the owner may toggle freely. Only the owner's req bit affects OWN.
- Invariants: grant is never multi-hot. sel is never 00 while busy=1. sel=00 while busy=0.

Optional Feature:
- Macro: HOLD_LIMIT_EN.
- Defined:
  - In OWN, when hold counter equals MAX_HOLD-1 and any other req bit is set, force release: grant=000 next edge, go to TURN.
  - If no other requester is pending, the owner keeps holding and the counter saturates.
  - A forced-out requester that keeps req high is re-arbitrated normally. It gets no priority.
- Not defined:
  - No counter logic is synthesised. Ownership ends only when the owner's req drops.
  - MAX_HOLD and CNT_W are unused.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=111 -> grant=000, sel=00, busy=0 throughout. Release rst with req=111 -> first edge grant=001, sel=11.
2. Rotation: req=111 constant, each owner drops its req for 1 cycle after 3 cycles owned, then re-raises it -> grant order 001,010,100,001. A 000 TURN cycle and an IDLE cycle separate each grant.
3. Single requester: only req[2] pulsed high 5 cycles -> grant=100 and sel=01 from edge t+1 to t+5. At t+6 grant=000. No other grant ever appears.
4. Owner release race: a owns, a drops req in the same cycle b rises -> grant 001 -> 000 (TURN) -> 000 (IDLE) -> 010. Never 011.
5. HOLD_LIMIT_EN, MAX_HOLD=4: a holds req, b requests at a's 2nd owned cycle -> a is granted exactly 4 cycles, then TURN, then b granted. Without the macro, a keeps the grant until its req drops.
6. Reset mid-OWN: b owns, rst=1 for 1 cycle -> grant=000 next edge. After reset, with req=110 held, b is granted first (pointer=2, search starts at a, whose req is 0).

Source files
------------

// File: rtl/mux3_rr_arbiter.sv
// Round-robin owner arbiter for a shared 3:1 select mux with a one-cycle turnaround between owners.
// Define HOLD_LIMIT_EN to force an owner out after MAX_HOLD cycles while another requester waits.
module mux3_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic [1:0] sel,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_e;

  state_e     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] ptr_q, ptr_d;
  logic       found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       owner_req;
  logic       force_rel;

  // Search starts one past the last winner and wraps 2 -> 0.
  always_comb begin
    found   = 1'b0;
    win_idx = 2'd0;
    cand    = ptr_q;
    for (int unsigned i = 0; i < 3; i++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign owner_req = |(req & grant_q);

`ifdef HOLD_LIMIT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             others_req;

  assign others_req = |(req & ~grant_q);
  assign force_rel  = (cnt_q == CNT_W'(MAX_HOLD - 1)) && others_req;

  always_comb begin
    cnt_d = '0;
    if (state_q == OWN && state_d == OWN) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;

  assign force_rel  = 1'b0;
  assign unused_cfg = ^{MAX_HOLD, CNT_W};
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (found) begin
          grant_d = 3'b001 << win_idx;
          ptr_d   = win_idx;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!owner_req || force_rel) begin
          grant_d = '0;
          state_d = TURN;
        end
      end
      TURN: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= 2'd2;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    sel = 2'b00;
    case (grant_q)
      3'b001:  sel = 2'b11;
      3'b010:  sel = 2'b10;
      3'b100:  sel = 2'b01;
      default: sel = 2'b00;
    endcase
  end

  assign grant = grant_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Scoreboard bench for mux3_rr_arbiter: a reference model pushes expected outputs per cycle,
// which are popped and compared after each rising edge, plus directed scenario checks.
module tb_mux3_rr_arbiter;

  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned CNT_W    = 4;
`ifdef HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       busy;

  always #5 clk = ~clk;

  mux3_rr_arbiter #(
    .MAX_HOLD(MAX_HOLD),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .grant(grant),
    .sel  (sel),
    .busy (busy)
  );

  typedef struct {
    logic [2:0] g;
    logic [1:0] s;
    logic       b;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] order[$];
  logic [2:0] obs_grant = 3'b000;
  int         n_tests = 0;
  int         n_fail  = 0;

  // Reference model state
  int         m_state = 0;  // 0 idle, 1 own, 2 turn
  int         m_ptr   = 2;
  int         m_cnt   = 0;
  int         m_age   = 0;
  logic [2:0] m_grant = 3'b000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] sel_of(input logic [2:0] g);
    case (g)
      3'b001:  return 2'b11;
      3'b010:  return 2'b10;
      3'b100:  return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic [2:0] rq);
    bit forced;
    if (r) begin
      m_state = 0; m_grant = 3'b000; m_ptr = 2; m_cnt = 0; m_age = 0;
    end else begin
      case (m_state)
        0: begin
          for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_ptr + k) % 3;
            if (rq[c]) begin
              m_grant = 3'b000;
              m_grant[c] = 1'b1;
              m_ptr = c; m_state = 1; m_cnt = 0; m_age = 1;
              break;
            end
          end
        end
        1: begin
          forced = HOLD_EN && (m_cnt == int'(MAX_HOLD) - 1) && ((rq & ~m_grant) != 3'b000);
          if (((rq & m_grant) == 3'b000) || forced) begin
            m_state = 2; m_grant = 3'b000; m_cnt = 0; m_age = 0;
          end else begin
            m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
            m_age++;
          end
        end
        default: begin
          m_state = 0; m_grant = 3'b000; m_cnt = 0;
        end
      endcase
    end
  endtask

  task automatic step(input logic r, input logic [2:0] rq);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    model_edge(r, rq);
    e.g = m_grant;
    e.s = sel_of(m_grant);
    e.b = (m_grant != 3'b000);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("grant", grant, e.g);
    check("sel", sel, e.s);
    check("busy", busy, e.b);
    if (obs_grant == 3'b000 && grant != 3'b000) order.push_back(grant);
    obs_grant = grant;
  endtask

  initial begin
    logic [2:0] rot_exp [4];
    logic [2:0] rq;
    logic [2:0] got_o;
    logic [2:0] next_g;
    int cnt_c, other, run;
    bit run_done;

    rot_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

    // Reset held with all requests pending, then release
    step(1'b1, 3'b111);
    step(1'b1, 3'b111);
    order.delete();
    step(1'b0, 3'b111);
    check("t1_grant", grant, 3'b001);
    check("t1_sel", sel, 2'b11);

    // Rotation: each owner drops its req for one cycle after 3 owned cycles
    for (int i = 0; i < 18; i++) begin
      rq = 3'b111;
      if (m_grant != 3'b000 && m_age >= 3) rq = rq & ~m_grant;
      step(1'b0, rq);
    end
    for (int i = 0; i < 4; i++) begin
      got_o = (i < order.size()) ? order[i] : 3'bxxx;
      check($sformatf("rot%0d", i), got_o, rot_exp[i]);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 3'b000);

    // Single requester c pulsed for 5 cycles
    cnt_c = 0;
    other = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'b100);
      if (grant == 3'b100) cnt_c++;
      else if (grant != 3'b000) other++;
    end
    step(1'b0, 3'b000);
    check("t3_release", grant, 3'b000);
    check("t3_len", cnt_c, 5);
    check("t3_other", other, 0);
    step(1'b0, 3'b000);
    step(1'b0, 3'b000);

    // Owner a drops in the same cycle b rises
    for (int i = 0; i < 3; i++) step(1'b0, 3'b001);
    step(1'b0, 3'b010);
    check("t4_turn", grant, 3'b000);
    step(1'b0, 3'b010);
    check("t4_idle", grant, 3'b000);
    step(1'b0, 3'b010);
    check("t4_b", grant, 3'b010);
    for (int i = 0; i < 3; i++) step(1'b0, 3'b000);

    // Hold limit: a holds, b joins during a's ownership
    run = 0;
    run_done = 1'b0;
    next_g = 3'b000;
    for (int i = 0; i < 16; i++) begin
      rq = (i < 2) ? 3'b001 : (i < 12) ? 3'b011 : 3'b010;
      step(1'b0, rq);
      if (!run_done && grant == 3'b001) run++;
      else if (run > 0) run_done = 1'b1;
      if (run_done && next_g == 3'b000 && grant != 3'b000) next_g = grant;
    end
    check("t5_hold", run, HOLD_EN ? 4 : 12);
    check("t5_next", next_g, 3'b010);
    for (int i = 0; i < 3; i++) step(1'b0, 3'b000);

    // Reset while b owns, then b wins first with req=110
    for (int i = 0; i < 3; i++) step(1'b0, 3'b010);
    check("t6_own", grant, 3'b010);
    step(1'b1, 3'b010);
    check("t6_rst", grant, 3'b000);
    step(1'b0, 3'b110);
    check("t6_first", grant, 3'b010);
    step(1'b0, 3'b110);
    step(1'b0, 3'b000);
    step(1'b0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
